// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front-end.
// Keeps a fetch PC, issues one synchronous memory read per cycle when credits
// allow, and queues the returned words in a 2-entry buffer for decode. A
// redirect flushes buffered and in-flight words and restarts fetch at a new PC.

module ifetch_unit #(
    parameter int                   PC_WIDTH  = 16,
    parameter int                   ISA_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = {PC_WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_en,
    input  logic                 redirect_valid,
    input  logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 mem_ren,
    output logic [PC_WIDTH-1:0]  mem_addr,
    input  logic [ISA_WIDTH-1:0] mem_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ISA_WIDTH-1:0] out_inst,
    output logic [PC_WIDTH-1:0]  out_pc
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [PC_WIDTH-1:0]  fpc_r;
    logic                 inflight_r;
    logic [PC_WIDTH-1:0]  tag_r;
    logic [1:0]           occ_r;
    logic                 rd_ptr_r;
    logic                 wr_ptr_r;
    logic [ISA_WIDTH-1:0] inst_q_r [0:1];
    logic [PC_WIDTH-1:0]  pc_q_r   [0:1];

    logic                 pop_s;
    logic                 push_s;
    logic                 issue_s;
    logic [2:0]           credit_s;

    // Handshake, push and credit-based issue decisions for this cycle.
    always_comb begin
        pop_s    = 1'b0;
        push_s   = 1'b0;
        issue_s  = 1'b0;
        credit_s = 3'd0;
        pop_s    = (occ_r != 2'd0) & out_ready;
        // A response landing in a redirect cycle belongs to the squashed path.
        push_s   = inflight_r & ~redirect_valid;
        // Words held or owed to the buffer after this cycle's pop; a pop only
        // happens with occ_r >= 1, so the subtraction cannot underflow.
        credit_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        if (rst_n && fetch_en && !redirect_valid && (credit_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    assign mem_ren   = issue_s;
    assign mem_addr  = fpc_r;
    assign out_valid = (occ_r != 2'd0);
    assign out_inst  = inst_q_r[rd_ptr_r];
    assign out_pc    = pc_q_r[rd_ptr_r];

    // Fetch PC, in-flight flag and tag of the outstanding read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc_r      <= RESET_PC;
            inflight_r <= 1'b0;
            tag_r      <= {PC_WIDTH{1'b0}};
        end else if (redirect_valid) begin
            fpc_r      <= redirect_pc;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                fpc_r <= fpc_r + PC_ONE;
                tag_r <= fpc_r;
            end
        end
    end

    // Two-entry output buffer; redirect empties it but a same-cycle pop still
    // counts as delivered because decode sampled the head this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_r       <= 2'd0;
            rd_ptr_r    <= 1'b0;
            wr_ptr_r    <= 1'b0;
            inst_q_r[0] <= {ISA_WIDTH{1'b0}};
            inst_q_r[1] <= {ISA_WIDTH{1'b0}};
            pc_q_r[0]   <= {PC_WIDTH{1'b0}};
            pc_q_r[1]   <= {PC_WIDTH{1'b0}};
        end else if (redirect_valid) begin
            occ_r    <= 2'd0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
        end else begin
            if (push_s) begin
                inst_q_r[wr_ptr_r] <= mem_rdata;
                pc_q_r[wr_ptr_r]   <= tag_r;
                wr_ptr_r           <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    ifetch_unit_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .occ   (occ_r)
    );

endmodule

// ifetch_unit_chk: the credit rule must keep pushes away from a full buffer.
module ifetch_unit_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       push,
    input logic [1:0] occ
);

    // Overflow of the output buffer would silently drop an instruction.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && (occ == 2'd2)));

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed stimulus for ifetch_unit with a scoreboard of
// expected {inst, pc} words popped by an independent monitor on each transfer.

module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, fetch_en, redirect_valid, out_ready;
    logic [15:0] redirect_pc;
    logic        mem_ren, out_valid;
    logic [15:0] mem_addr, mem_rdata, out_inst, out_pc;

    logic        w_rst_n;
    logic        w_mem_ren, w_out_valid;
    logic [15:0] w_mem_addr, w_mem_rdata, w_out_inst, w_out_pc;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] wexp_q [$];

    always #5 clk = ~clk;

    ifetch_unit #(.PC_WIDTH(16), .ISA_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc)
    );

    ifetch_unit #(.PC_WIDTH(16), .ISA_WIDTH(16), .RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst_n(w_rst_n), .fetch_en(1'b1),
        .redirect_valid(1'b0), .redirect_pc(16'h0000),
        .mem_ren(w_mem_ren), .mem_addr(w_mem_addr), .mem_rdata(w_mem_rdata),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_inst(w_out_inst), .out_pc(w_out_pc)
    );

    // Instruction memory model: word at address a holds 0x1000 + a, one-cycle read.
    always @(posedge clk) begin
        if (mem_ren)   mem_rdata   <= 16'h1000 + mem_addr;
        if (w_mem_ren) w_mem_rdata <= 16'h1000 + w_mem_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [31:0] ent(input logic [15:0] pc);
        logic [15:0] inst;
        inst = 16'h1000 + pc;
        return {inst, pc};
    endfunction

    task automatic exp_seq(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(ent(start + 16'(i)));
    endtask

    // Monitor: every accepted word must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got pc %h inst %h, required no word", out_pc, out_inst);
            end else begin
                chk("stream_word", {out_inst, out_pc}, exp_q.pop_front());
            end
        end
        if (w_rst_n && w_out_valid && (wexp_q.size() != 0)) begin
            chk("wrap_word", {w_out_inst, w_out_pc}, wexp_q.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0; w_rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 16'h0000;
        wexp_q.push_back(32'h0FFE_FFFE);
        wexp_q.push_back(32'h0FFF_FFFF);
        wexp_q.push_back(32'h1000_0000);
        wexp_q.push_back(32'h1001_0001);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_mem_ren",   {31'd0, mem_ren},   32'd0);
        chk("reset_out_pc",    {16'd0, out_pc},    32'd0);
        chk("reset_out_inst",  {16'd0, out_inst},  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; w_rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            out_ready      = !((c >= 8 && c <= 12) || c == 16 || c == 17 || c == 36 || c == 37);
            fetch_en       = !((c >= 44 && c <= 46) || c >= 53);
            rst_n          = (c != 37);
            redirect_valid = (c == 17 || c == 23 || c == 28 || c == 29);
            redirect_pc    = (c == 28) ? 16'h0100 : ((c == 29) ? 16'h0200 : 16'h0040);
            case (c)
                0:       exp_seq(16'h0000, 9);
                17:      exp_seq(16'h0040, 4);
                23:      exp_seq(16'h0040, 3);
                29:      exp_seq(16'h0200, 4);
                38:      exp_seq(16'h0000, 12);
                default: ;
            endcase
            @(negedge clk);
            case (c)
                0: begin
                    chk("first_issue_ren",  {31'd0, mem_ren},   32'd1);
                    chk("first_issue_addr", {16'd0, mem_addr},  32'h0000);
                    chk("c0_out_valid",     {31'd0, out_valid}, 32'd0);
                end
                1:  chk("c1_out_valid", {31'd0, out_valid}, 32'd0);
                2: begin
                    chk("c2_out_valid", {31'd0, out_valid}, 32'd1);
                    chk("c2_out_pc",    {16'd0, out_pc},    32'h0000);
                end
                8:  chk("bp_no_issue", {31'd0, mem_ren}, 32'd0);
                9, 10, 11, 12: begin
                    chk("bp_ren_low",     {31'd0, mem_ren},  32'd0);
                    chk("bp_inst_stable", {16'd0, out_inst}, 32'h1006);
                    chk("bp_pc_stable",   {16'd0, out_pc},   32'h0006);
                end
                13: begin
                    chk("bp_resume_ren",  {31'd0, mem_ren},  32'd1);
                    chk("bp_resume_addr", {16'd0, mem_addr}, 32'h0008);
                end
                18: begin
                    chk("redir_valid_low", {31'd0, out_valid}, 32'd0);
                    chk("redir_issue_ren", {31'd0, mem_ren},   32'd1);
                    chk("redir_issue_pc",  {16'd0, mem_addr},  32'h0040);
                end
                19: chk("redir_r2_valid", {31'd0, out_valid}, 32'd0);
                24: begin
                    chk("redir_pop_valid", {31'd0, out_valid}, 32'd0);
                    chk("redir_pop_addr",  {16'd0, mem_addr},  32'h0040);
                end
                29: chk("b2b_no_issue", {31'd0, mem_ren}, 32'd0);
                30: begin
                    chk("b2b_last_wins_ren", {31'd0, mem_ren},  32'd1);
                    chk("b2b_last_wins_pc",  {16'd0, mem_addr}, 32'h0200);
                end
                37: chk("rst_ren_low", {31'd0, mem_ren}, 32'd0);
                38: begin
                    chk("rst_flush_valid", {31'd0, out_valid}, 32'd0);
                    chk("rst_restart_ren", {31'd0, mem_ren},   32'd1);
                    chk("rst_restart_pc",  {16'd0, mem_addr},  32'h0000);
                end
                44, 45: chk("fen_low_ren", {31'd0, mem_ren}, 32'd0);
                46: begin
                    chk("fen_low_ren",   {31'd0, mem_ren},   32'd0);
                    chk("fen_drained",   {31'd0, out_valid}, 32'd0);
                    chk("fen_fpc_held",  {16'd0, mem_addr},  32'h0006);
                end
                47: begin
                    chk("fen_resume_ren", {31'd0, mem_ren},  32'd1);
                    chk("fen_resume_pc",  {16'd0, mem_addr}, 32'h0006);
                end
                default: ;
            endcase
            @(posedge clk);
            #1;
        end
        chk("all_words_delivered",  32'(exp_q.size()),  32'd0);
        chk("wrap_words_delivered", 32'(wexp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
